// File: rtl/audio_sample_fifo_if.sv
// Stereo sample stream between the core producer, the pacing FIFO and audio_sys.
// The producer side (core) drives master; the FIFO itself is the slave.
interface audio_sample_fifo_if;
  logic        in_valid;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic        in_ready;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_strobe;

  modport master (
    output in_valid, in_l, in_r,
    input  in_ready, out_l, out_r, out_strobe
  );

  modport slave (
    input  in_valid, in_l, in_r,
    output in_ready, out_l, out_r, out_strobe
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO that absorbs bursty core writes and releases one pair per
// output-rate tick from a fractional accumulator, with sticky over/underflow flags.
module audio_sample_fifo #(
  parameter int unsigned CLK_HZ     = 24576000,
  parameter int unsigned RATE_HZ    = 48000,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_audio,
  input  logic                  reset,
  audio_sample_fifo_if.slave    smp,
  input  logic                  clr_flags,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  HALF_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]  PTR_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [32:0]          RATE_INC   = 33'(RATE_HZ);
  localparam logic [32:0]          CLK_MOD    = 33'(CLK_HZ);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [DEPTH_LOG2:0]  wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]  rptr_q, rptr_d;
  logic [15:0]          out_l_q, out_l_d;
  logic [15:0]          out_r_q, out_r_d;
  logic                 strobe_q, strobe_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          rd_data;
  logic [32:0]          acc_sum;
  logic                 tick;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Extra pointer bit distinguishes a full FIFO from an empty one.
  assign level   = wptr_q - rptr_q;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign rd_data = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // Phase accumulator wraps modulo CLK_HZ, giving exactly RATE_HZ ticks per second.
  always_comb begin
    acc_sum = {1'b0, acc_q} + RATE_INC;
    tick    = (acc_sum >= CLK_MOD);
    acc_d   = tick ? 32'(acc_sum - CLK_MOD) : acc_sum[31:0];
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    strobe_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (clr_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    // Acceptance uses the start-of-cycle level, so a same-cycle pop never frees a slot.
    if (smp.in_valid) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        push   = 1'b1;
        wptr_d = wptr_q + PTR_ONE;
      end
    end

    case (state_q)
      PRIME: begin
        if (level >= HALF_LEVEL) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (empty) begin
            underflow_d = 1'b1;
            state_d     = PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = PRIME;
    endcase

    if (pop) begin
      rptr_d   = rptr_q + PTR_ONE;
      out_l_d  = rd_data[31:16];
      out_r_d  = rd_data[15:0];
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      state_q     <= PRIME;
      acc_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      strobe_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      strobe_q    <= strobe_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: pointers define which entries are valid.
  always_ff @(posedge clk_audio) begin
    if (push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {smp.in_l, smp.in_r};
    end
  end

  assign smp.in_ready   = ~full;
  assign smp.out_l      = out_l_q;
  assign smp.out_r      = out_r_q;
  assign smp.out_strobe = strobe_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: a fast-tick instance (tick every 10 cycles)
// and a default-rate instance (tick every 512 cycles) share clock and reset.
module tb_audio_sample_fifo;

  logic       clk_audio = 1'b0;
  logic       reset;
  logic       clr1, clr2;
  logic [4:0] level1, level2;
  logic       ovf1, unf1, ovf2, unf2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];

  audio_sample_fifo_if if1();
  audio_sample_fifo_if if2();

  audio_sample_fifo #(.CLK_HZ(480000), .RATE_HZ(48000), .DEPTH_LOG2(4)) dut1 (
    .clk_audio (clk_audio),
    .reset     (reset),
    .smp       (if1),
    .clr_flags (clr1),
    .level     (level1),
    .overflow  (ovf1),
    .underflow (unf1)
  );

  audio_sample_fifo #(.CLK_HZ(24576000), .RATE_HZ(48000), .DEPTH_LOG2(4)) dut2 (
    .clk_audio (clk_audio),
    .reset     (reset),
    .smp       (if2),
    .clr_flags (clr2),
    .level     (level2),
    .overflow  (ovf2),
    .underflow (unf2)
  );

  always #5 clk_audio = ~clk_audio;

  // Reset is released on a negedge so the next posedge is cycle 1 with acc=0.
  task automatic do_reset();
    reset = 1'b1;
    if1.in_valid = 1'b0; if1.in_l = '0; if1.in_r = '0;
    if2.in_valid = 1'b0; if2.in_l = '0; if2.in_r = '0;
    clr1 = 1'b0;
    clr2 = 1'b0;
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk_audio);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (level1 !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d want 0", level1); end
    n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", if1.in_ready); end
    n_checks++; if ({if1.out_l, if1.out_r} !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out: got %h want 0", {if1.out_l, if1.out_r}); end
    n_checks++; if (if1.out_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe: got %b want 0", if1.out_strobe); end
    n_checks++; if ({ovf1, unf1, ovf2, unf2} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {ovf1, unf1, ovf2, unf2}); end
    n_checks++; if (level2 !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_level2: got %0d want 0", level2); end
  endtask

  // Prime with 8, drain 8, underflow on the 9th tick, clear flags, then re-prime.
  task automatic test_prime_and_underflow();
    int pushed = 0;
    int pops = 0;
    logic exp_strobe;
    logic exp_unf;
    logic [31:0] w;
    do_reset();
    if1.in_valid = 1'b1; if1.in_l = 16'h1000; if1.in_r = 16'h2000;
    q1.push_back(32'h1000_2000);
    pushed = 1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk_audio);
      exp_strobe = ((c % 10 == 0) && (c <= 80)) || (c == 150);
      if (exp_strobe) pops++;
      n_checks++;
      if (if1.out_strobe !== exp_strobe) begin
        n_fail++; $display("[TB] FAIL prime_strobe c=%0d: got %b want %b", c, if1.out_strobe, exp_strobe);
      end
      if (if1.out_strobe === 1'b1) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++; $display("[TB] FAIL prime_data c=%0d: got strobe with %h, want no strobe", c, {if1.out_l, if1.out_r});
        end else begin
          w = q1.pop_front();
          if ({if1.out_l, if1.out_r} !== w) begin
            n_fail++; $display("[TB] FAIL prime_data c=%0d: got %h want %h", c, {if1.out_l, if1.out_r}, w);
          end
        end
      end
      n_checks++;
      if (level1 !== 5'(pushed - pops)) begin
        n_fail++; $display("[TB] FAIL prime_level c=%0d: got %0d want %0d", c, level1, pushed - pops);
      end
      exp_unf = (c >= 90 && c <= 140);
      n_checks++;
      if (unf1 !== exp_unf) begin
        n_fail++; $display("[TB] FAIL underflow c=%0d: got %b want %b", c, unf1, exp_unf);
      end
      if (c == 90) begin
        n_checks++;
        if (if1.out_l !== 16'h1007) begin
          n_fail++; $display("[TB] FAIL underflow_hold: got %h want 1007", if1.out_l);
        end
      end
      clr1 = (c == 140);
      if (c < 8 || (c >= 140 && c < 148)) begin
        if1.in_valid = 1'b1;
        if1.in_l = (c < 8) ? 16'(32'h1000 + c) : 16'(32'h1100 + c - 140);
        if1.in_r = (c < 8) ? 16'(32'h2000 + c) : 16'(32'h2100 + c - 140);
        q1.push_back({if1.in_l, if1.in_r});
        pushed++;
      end else begin
        if1.in_valid = 1'b0;
      end
    end
    clr1 = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  // Level held at 5 by pushing on each tick; 43 pops wrap rptr/wptr twice.
  task automatic test_back_to_back();
    int pushed = 0;
    int pops = 0;
    int extra = 0;
    logic exp_strobe;
    logic [31:0] w;
    do_reset();
    if1.in_valid = 1'b1; if1.in_l = 16'h4000; if1.in_r = 16'h5000;
    q1.push_back(32'h4000_5000);
    pushed = 1;
    for (int c = 1; c <= 435; c++) begin
      @(negedge clk_audio);
      exp_strobe = (c % 10 == 0);
      if (exp_strobe) pops++;
      n_checks++;
      if (if1.out_strobe !== exp_strobe) begin
        n_fail++; $display("[TB] FAIL b2b_strobe c=%0d: got %b want %b", c, if1.out_strobe, exp_strobe);
      end
      if (if1.out_strobe === 1'b1) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_data c=%0d: got strobe with %h, want no strobe", c, {if1.out_l, if1.out_r});
        end else begin
          w = q1.pop_front();
          if ({if1.out_l, if1.out_r} !== w) begin
            n_fail++; $display("[TB] FAIL b2b_data c=%0d: got %h want %h", c, {if1.out_l, if1.out_r}, w);
          end
        end
      end
      n_checks++;
      if (level1 !== 5'(pushed - pops)) begin
        n_fail++; $display("[TB] FAIL b2b_level c=%0d: got %0d want %0d", c, level1, pushed - pops);
      end
      if (c < 8 || (c >= 39 && (c + 1) % 10 == 0 && extra < 40)) begin
        if (c >= 8) extra++;
        if1.in_valid = 1'b1;
        if1.in_l = 16'(32'h4000 + pushed);
        if1.in_r = 16'(32'h5000 + pushed);
        q1.push_back({if1.in_l, if1.in_r});
        pushed++;
      end else begin
        if1.in_valid = 1'b0;
      end
    end
    if1.in_valid = 1'b0;
  endtask

  // Default rate: fill past full, flag priority over clear, drop on full+pop, 512-cycle spacing.
  task automatic test_overflow_and_rate();
    int pushed = 0;
    int pops = 0;
    int attempts = 0;
    logic exp_strobe;
    logic exp_ovf;
    logic exp_ready;
    logic [31:0] w;
    do_reset();
    if2.in_valid = 1'b1; if2.in_l = 16'h3000; if2.in_r = 16'h3800;
    q2.push_back(32'h3000_3800);
    pushed = 1;
    attempts = 1;
    for (int c = 1; c <= 1030; c++) begin
      @(negedge clk_audio);
      exp_strobe = (c % 512 == 0);
      if (exp_strobe) pops++;
      n_checks++;
      if (if2.out_strobe !== exp_strobe) begin
        n_fail++; $display("[TB] FAIL rate_strobe c=%0d: got %b want %b", c, if2.out_strobe, exp_strobe);
      end
      if (if2.out_strobe === 1'b1) begin
        n_checks++;
        if (q2.size() == 0) begin
          n_fail++; $display("[TB] FAIL rate_data c=%0d: got strobe with %h, want no strobe", c, {if2.out_l, if2.out_r});
        end else begin
          w = q2.pop_front();
          if ({if2.out_l, if2.out_r} !== w) begin
            n_fail++; $display("[TB] FAIL rate_data c=%0d: got %h want %h", c, {if2.out_l, if2.out_r}, w);
          end
        end
      end
      n_checks++;
      if (level2 !== 5'(pushed - pops)) begin
        n_fail++; $display("[TB] FAIL ovf_level c=%0d: got %0d want %0d", c, level2, pushed - pops);
      end
      exp_ready = (pushed - pops < 16);
      n_checks++;
      if (if2.in_ready !== exp_ready) begin
        n_fail++; $display("[TB] FAIL ovf_in_ready c=%0d: got %b want %b", c, if2.in_ready, exp_ready);
      end
      exp_ovf = (c == 17) || (c == 18) || (c >= 512);
      n_checks++;
      if (ovf2 !== exp_ovf) begin
        n_fail++; $display("[TB] FAIL overflow c=%0d: got %b want %b", c, ovf2, exp_ovf);
      end
      n_checks++;
      if (unf2 !== 1'b0) begin
        n_fail++; $display("[TB] FAIL ovf_underflow c=%0d: got %b want 0", c, unf2);
      end
      clr2 = (c == 17) || (c == 18);
      if (c <= 17 || c == 511) begin
        if2.in_valid = 1'b1;
        if2.in_l = 16'(32'h3000 + attempts);
        if2.in_r = 16'(32'h3800 + attempts);
        attempts++;
        if (pushed - pops < 16) begin
          q2.push_back({if2.in_l, if2.in_r});
          pushed++;
        end
      end else begin
        if2.in_valid = 1'b0;
      end
    end
    clr2 = 1'b0;
    if2.in_valid = 1'b0;
  endtask

  // Async reset at level 6 clears everything before the next edge; re-prime from empty.
  task automatic test_reset_midstream();
    int pushed = 0;
    int pops = 0;
    logic exp_strobe;
    logic [31:0] w;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) do_reset();
      pushed = 1;
      pops = 0;
      if1.in_valid = 1'b1;
      if1.in_l = (pass == 0) ? 16'h6000 : 16'h7000;
      if1.in_r = (pass == 0) ? 16'h6800 : 16'h7800;
      q1.push_back({if1.in_l, if1.in_r});
      for (int c = 1; c <= 24; c++) begin
        @(negedge clk_audio);
        exp_strobe = (c % 10 == 0);
        if (exp_strobe) pops++;
        n_checks++;
        if (if1.out_strobe !== exp_strobe) begin
          n_fail++; $display("[TB] FAIL rst_strobe p=%0d c=%0d: got %b want %b", pass, c, if1.out_strobe, exp_strobe);
        end
        if (if1.out_strobe === 1'b1) begin
          n_checks++;
          if (q1.size() == 0) begin
            n_fail++; $display("[TB] FAIL rst_data c=%0d: got strobe with %h, want no strobe", c, {if1.out_l, if1.out_r});
          end else begin
            w = q1.pop_front();
            if ({if1.out_l, if1.out_r} !== w) begin
              n_fail++; $display("[TB] FAIL rst_data p=%0d c=%0d: got %h want %h", pass, c, {if1.out_l, if1.out_r}, w);
            end
          end
        end
        n_checks++;
        if (level1 !== 5'(pushed - pops)) begin
          n_fail++; $display("[TB] FAIL rst_level p=%0d c=%0d: got %0d want %0d", pass, c, level1, pushed - pops);
        end
        if (c < 8) begin
          if1.in_valid = 1'b1;
          if1.in_l = 16'(((pass == 0) ? 32'h6000 : 32'h7000) + c);
          if1.in_r = 16'(((pass == 0) ? 32'h6800 : 32'h7800) + c);
          q1.push_back({if1.in_l, if1.in_r});
          pushed++;
        end else begin
          if1.in_valid = 1'b0;
        end
      end
      if (pass == 0) begin
        #2 reset = 1'b1;
        #1;
        n_checks++; if (level1 !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_level: got %0d want 0", level1); end
        n_checks++; if ({if1.out_l, if1.out_r} !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_out: got %h want 0", {if1.out_l, if1.out_r}); end
        n_checks++; if ({ovf1, unf1} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b want 00", {ovf1, unf1}); end
        n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b want 1", if1.in_ready); end
        q1.delete();
        @(negedge clk_audio);
        reset = 1'b0;
      end
    end
    if1.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr1 = 1'b0;
    clr2 = 1'b0;
    if1.in_valid = 1'b0; if1.in_l = '0; if1.in_r = '0;
    if2.in_valid = 1'b0; if2.in_l = '0; if2.in_r = '0;
    $display("[TB] starting audio_sample_fifo bench");
    test_reset();
    test_prime_and_underflow();
    test_back_to_back();
    test_overflow_and_rate();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
